sumres_acc_ctrl: RTL and testbench
==================================

SUMRES_ACC_CTRL -- requirements
Module: sumres_acc_ctrl

Interface
REQ-001 Parameter: DEPTH, default 4, command FIFO entries; SHALL be a power of two, >= 2.
REQ-002 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  FIFO can accept; SHALL equal !full.
REQ-006 cmd_op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR.
REQ-007 cmd_b  in  4  operand B.
REQ-008 add_a  out  4  adder operand A, driven from accumulator.
REQ-009 add_b  out  4  adder operand B, true or inverted.
REQ-010 add_ci  out  1  adder carry-in.
REQ-011 add_s  in  5  combinational adder result: add_s[3:0] sum, add_s[4] carry-out, valid in the same cycle.
REQ-012 res_valid  out  1  result available.
REQ-013 res_ready  in  1  consumer accepts result.
REQ-014 res_data  out  4  registered result.
REQ-015 res_c, res_v, res_z  out  1 each  carry, signed overflow, zero flags.
REQ-016 acc_q  out  4  current accumulator value.

Function
REQ-017 Command accepted on an edge where cmd_valid && cmd_ready; pushed into FIFO in order.
REQ-018 FSM states IDLE, EXEC, RESP; IDLE with FIFO non-empty SHALL pop head and enter EXEC on that edge; IDLE with FIFO empty SHALL stay IDLE.
REQ-019 EXEC lasts exactly one cycle; on its closing edge acc, res_data and flags SHALL load and FSM enters RESP.
REQ-020 RESP: res_valid=1; on an edge with res_ready=1 enter IDLE; res_data/flags SHALL hold stable while res_valid && !res_ready.
REQ-021 Latency: command accepted on edge k into an empty FIFO with FSM IDLE -> res_valid high after edge k+2; max throughput one op per 3 cycles.
REQ-022 EXEC drive: ADD add_a=acc, add_b=b, add_ci=0; SUB add_a=acc, add_b=~b, add_ci=1; LOAD/CLR drive 0s. Outside EXEC add_a/add_b/add_ci SHALL be 0.
REQ-023 ADD/SUB result: acc=res_data=add_s[3:0]; res_c=add_s[4]; res_v=(add_a[3]==add_b[3]) && (add_s[3]!=add_a[3]); res_z=(add_s[3:0]==0).
REQ-024 LOAD: acc=res_data=b, c=0, v=0, z=(b==0). CLR: acc=res_data=0, c=0, v=0, z=1.
REQ-025 Arithmetic wraps modulo 16; no saturation.
REQ-026 Push and pop on same edge SHALL leave count unchanged; push while full SHALL NOT occur (cmd_ready=0); pop while empty SHALL NOT occur.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; full/empty from separate count of 0..DEPTH.
REQ-028 cmd_op/cmd_b when cmd_valid=0 SHALL be ignored.

Reset
REQ-029 While rst_n=0 (asynchronously): state IDLE, FIFO empty, acc_q=0, res_data=0, res_c=res_v=res_z=0, res_valid=0, add_a=add_b=add_ci=0, cmd_ready=1.
REQ-030 Reset mid-operation SHALL discard queued commands and any in-flight EXEC/RESP result; no result emitted after release until a new command.
REQ-031 First command SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-032 LOAD 5 then ADD 3, res_ready=1 -> results 5 (z0) then 8, c=0, v=1, z=0; in EXEC add_a=5, add_b=3, add_ci=0.
REQ-033 LOAD 3, SUB 3 -> add_b=4'b1100, add_ci=1; result 0, c=1, v=0, z=1.
REQ-034 LOAD 2, SUB 5 -> result 13 (4'b1101), c=0, v=0, z=0; LOAD 15, ADD 1 -> result 0, c=1, v=0, z=1.
REQ-035 res_ready=0, cmd_valid held high with 6 distinct LOADs, DEPTH=4 -> exactly 5 accepted (1 executing + 4 queued), cmd_ready=0 afterwards, res_data stable; release res_ready -> 5 results in order, cmd_ready returns 1 after first pop.
REQ-036 rst_n pulled low during EXEC of ADD with 2 commands queued -> all outputs to REQ-029 values immediately without clock edge; after release no res_valid until new command; acc_q=0.
REQ-037 Single command timing: cmd accepted edge k -> EXEC during cycle k+1..k+2, res_valid high from edge k+2 until edge with res_ready=1.

Source files
------------

// File: rtl/sumres_acc_ctrl_if.sv
// Command and result bus of the accumulator controller.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender keeps its payload stable while valid && !ready.
interface sumres_acc_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_b;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_c;
    logic       res_v;
    logic       res_z;

    modport master (
        output cmd_valid, cmd_op, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_c, res_v, res_z
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_c, res_v, res_z
    );
endinterface

// File: rtl/sumres_acc_ctrl.sv
// 4-bit accumulator controller: queues LOAD/ADD/SUB/CLR commands in a FIFO and
// sequences each through an external combinational adder, one result per command.
module sumres_acc_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sumres_acc_ctrl_if.slave bus,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_ci,
    input  logic [4:0]       add_s,
    output logic [3:0]       acc_q,
    output logic [1:0]       state_dbg
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       mem_q [DEPTH];
    logic [5:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       b_q, b_d;
    logic [3:0]       acc_d;
    logic [3:0]       res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic             res_c_q, res_c_d, res_v_q, res_v_d, res_z_q, res_z_d;
    logic [3:0]       add_a_q, add_a_d, add_b_q, add_b_d;
    logic             add_ci_q, add_ci_d;
    logic             cmd_ready, push, pop;
    logic [5:0]       head;

    assign cmd_ready = (count_q != CNT_W'(DEPTH));
    assign push      = bus.cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        op_d        = op_q;
        b_d         = b_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_c_d     = res_c_q;
        res_v_d     = res_v_q;
        res_z_d     = res_z_q;
        add_a_d     = '0;
        add_b_d     = '0;
        add_ci_d    = 1'b0;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.cmd_op, bus.cmd_b};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        case (state_q)
            S_IDLE: begin
                // Adder operands are registered on the pop edge so they are valid for the whole EXEC cycle.
                if (pop) begin
                    state_d = S_EXEC;
                    op_d    = head[5:4];
                    b_d     = head[3:0];
                    if (head[5:4] == OP_ADD) begin
                        add_a_d = acc_q;
                        add_b_d = head[3:0];
                    end else if (head[5:4] == OP_SUB) begin
                        add_a_d  = acc_q;
                        add_b_d  = ~head[3:0];
                        add_ci_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                state_d     = S_RESP;
                res_valid_d = 1'b1;
                res_c_d     = 1'b0;
                res_v_d     = 1'b0;
                if (op_q == OP_ADD || op_q == OP_SUB) begin
                    acc_d   = add_s[3:0];
                    res_c_d = add_s[4];
                    res_v_d = (add_a_q[3] == add_b_q[3]) && (add_s[3] != add_a_q[3]);
                end else if (op_q == OP_LOAD) begin
                    acc_d = b_q;
                end else begin
                    acc_d = 4'd0;
                end
                res_z_d    = (acc_d == 4'd0);
                res_data_d = acc_d;
            end
            S_RESP: begin
                if (bus.res_ready) begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_q        <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_c_q     <= 1'b0;
            res_v_q     <= 1'b0;
            res_z_q     <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_ci_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            op_q        <= op_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_c_q     <= res_c_d;
            res_v_q     <= res_v_d;
            res_z_q     <= res_z_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_ci_q    <= add_ci_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_c     = res_c_q;
    assign bus.res_v     = res_v_q;
    assign bus.res_z     = res_z_q;
    assign add_a         = add_a_q;
    assign add_b         = add_b_q;
    assign add_ci        = add_ci_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_sumres_acc_ctrl.sv
// Bench for sumres_acc_ctrl: arithmetic reference model feeds expected queues,
// a negedge monitor compares results and adder drive independently of the stimulus.
module tb_sumres_acc_ctrl;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;

    logic       clk;
    logic       rst_n;
    logic [3:0] add_a, add_b, acc_q;
    logic       add_ci;
    logic [4:0] add_s;
    logic [1:0] state_dbg;

    sumres_acc_ctrl_if bus ();

    sumres_acc_ctrl #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_s     (add_s),
        .acc_q     (acc_q),
        .state_dbg (state_dbg)
    );

    // External combinational adder
    assign add_s = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [6:0] exp_q[$];       // {data, c, v, z}
    logic [8:0] exp_add_q[$];   // {add_a, add_b, add_ci} expected during EXEC
    logic [3:0] m_acc = 4'd0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event missing or unexpected", name);
    endfunction

    function automatic int sgn(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    // Reference model: plain integer arithmetic on the 4-bit accumulator
    function automatic void model_push(input logic [1:0] op, input logic [3:0] b);
        int a, bb, s, sr;
        logic [3:0] r;
        logic c, v;
        logic [8:0] ad;
        a = int'(m_acc);
        bb = int'(b);
        r = 4'd0; c = 1'b0; v = 1'b0; ad = 9'd0;
        case (op)
            OP_LOAD: r = b;
            OP_ADD: begin
                s = a + bb; r = 4'(s % 16); c = (s > 15);
                sr = sgn(a) + sgn(bb); v = (sr > 7) || (sr < -8);
                ad = {4'(a), 4'(bb), 1'b0};
            end
            OP_SUB: begin
                s = a - bb; r = 4'((s + 16) % 16); c = (a >= bb);
                sr = sgn(a) - sgn(bb); v = (sr > 7) || (sr < -8);
                ad = {4'(a), 4'(15 - bb), 1'b1};
            end
            default: r = 4'd0;
        endcase
        m_acc = r;
        exp_q.push_back({r, c, v, (r == 4'd0)});
        exp_add_q.push_back(ad);
    endfunction

    // ---------------- monitor ----------------
    logic       stable_chk = 1'b0;
    logic [6:0] prev_word;

    always @(negedge clk) begin : monitor
        logic [6:0] got;
        got = {bus.res_data, bus.res_c, bus.res_v, bus.res_z};
        if (!rst_n) begin
            stable_chk = 1'b0;
        end else begin
            if (stable_chk) begin
                chk("res_hold_valid", 32'(bus.res_valid), 32'd1);
                chk("res_hold_data", 32'(got), 32'(prev_word));
            end
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) fail("res_unexpected");
                else chk("res_word", 32'(got), 32'(exp_q.pop_front()));
            end
            stable_chk = bus.res_valid && !bus.res_ready;
            prev_word  = got;
            if (state_dbg == ST_EXEC) begin
                if (exp_add_q.size() == 0) fail("adder_unexpected_exec");
                else chk("adder_exec", 32'({add_a, add_b, add_ci}), 32'(exp_add_q.pop_front()));
            end else begin
                chk("adder_idle_zero", 32'({add_a, add_b, add_ci}), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic v, input logic [1:0] op, input logic [3:0] b,
                         input logic rdy, output logic ok);
        bus.cmd_valid = v;
        bus.cmd_op    = v ? op : 2'($urandom_range(0, 3));
        bus.cmd_b     = v ? b  : 4'($urandom_range(0, 15));
        bus.res_ready = rdy;
        @(negedge clk);
        ok = v && bus.cmd_ready;
        @(posedge clk);
        if (ok) model_push(op, b);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] b);
        logic ok;
        int t;
        ok = 1'b0;
        t = 0;
        while (!ok && t < 50) begin
            cycle(1'b1, op, b, 1'b1, ok);
            t++;
        end
        if (!ok) fail("send_timeout");
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.res_valid) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) fail("drain_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_word"}, 32'({bus.res_data, bus.res_c, bus.res_v, bus.res_z}), 32'd0);
        chk({tag, "_acc"}, 32'(acc_q), 32'd0);
        chk({tag, "_adder"}, 32'({add_a, add_b, add_ci}), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    // ---------------- main stimulus ----------------
    initial begin : main
        logic ok;
        int idx, found;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_b = 4'd0;
        bus.res_ready = 1'b0;
        #12;
        check_reset_outputs("reset");

        // First command on the first rising edge after release
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1'b1, OP_LOAD, 4'd5, 1'b1, ok);
        chk("first_cmd_accept", 32'(ok), 32'd1);
        bus.cmd_valid = 1'b0;

        // Directed arithmetic cases
        send(OP_ADD, 4'd3);
        send(OP_LOAD, 4'd3);  send(OP_SUB, 4'd3);
        send(OP_LOAD, 4'd2);  send(OP_SUB, 4'd5);
        send(OP_LOAD, 4'd15); send(OP_ADD, 4'd1);
        send(OP_CLR, 4'd9);   send(OP_SUB, 4'd1);
        send(OP_LOAD, 4'd7);  send(OP_ADD, 4'd1);
        send(OP_LOAD, 4'd8);  send(OP_SUB, 4'd1);
        drain();

        // Single-command latency
        cycle(1'b1, OP_LOAD, 4'd9, 1'b0, ok);
        bus.cmd_valid = 1'b0;
        chk("lat_accept", 32'(ok), 32'd1);
        @(negedge clk);
        chk("lat_k_valid", 32'(bus.res_valid), 32'd0);
        chk("lat_k_state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        chk("lat_k1_state", 32'(state_dbg), 32'(ST_EXEC));
        chk("lat_k1_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        chk("lat_k2_valid", 32'(bus.res_valid), 32'd1);
        @(negedge clk);
        chk("lat_k3_hold", 32'(bus.res_valid), 32'd1);
        @(posedge clk);
        #1 drain();

        // FIFO fill with the consumer stalled
        idx = 0;
        for (int cy = 0; cy < 10; cy++) begin
            if (idx < 6) begin
                cycle(1'b1, OP_LOAD, 4'(idx * 2 + 3), 1'b0, ok);
                if (ok) idx++;
            end
        end
        chk("fill_accepted", 32'(idx), 32'd5);
        chk("fill_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        for (int cy = 0; cy < 40 && idx < 6; cy++) begin
            cycle(1'b1, OP_LOAD, 4'(idx * 2 + 3), 1'b1, ok);
            if (ok) idx++;
        end
        chk("fill_last_accepted", 32'(idx), 32'd6);
        drain();

        // Asynchronous reset during EXEC of an ADD with two commands queued
        cycle(1'b1, OP_LOAD, 4'd1, 1'b0, ok);
        cycle(1'b1, OP_ADD, 4'd2, 1'b0, ok);
        cycle(1'b1, OP_ADD, 4'd3, 1'b0, ok);
        cycle(1'b1, OP_ADD, 4'd4, 1'b0, ok);
        bus.cmd_valid = 1'b0;
        chk("rst_pre_queued", 32'(exp_q.size()), 32'd4);
        bus.res_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            @(negedge clk);
            if (state_dbg == ST_EXEC) found = 1;
        end
        chk("rst_found_exec", 32'(found), 32'd1);
        chk("rst_pre_acc", 32'(acc_q), 32'd1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        exp_add_q.delete();
        m_acc = 4'd0;
        #1 check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, OP_LOAD, 4'd0, 1'b1, ok);
            chk("post_rst_no_valid", 32'(bus.res_valid), 32'd0);
            chk("post_rst_acc", 32'(acc_q), 32'd0);
        end

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 250; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0), ok);
        end
        drain();
        chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("final_exp_add_q_empty", 32'(exp_add_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        fail("watchdog_timeout");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
